// File: rtl/palette_port_arbiter.sv
// Two-way arbiter for palette RAM port B: render has fixed priority, host forced through after MAX_STARVE denials.
// Grants are combinational, read valids return RD_LATENCY cycles after grant; requesters hold until granted.
module palette_port_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rend_req,
    input  logic [9:0]  rend_addr,
    output logic        rend_gnt,
    output logic        rend_rvalid,
    output logic [31:0] rend_rdata,
    input  logic        host_valid,
    input  logic        host_we,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ready,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [3:0]            starve_cnt;
    logic                  force_host;
    logic                  host_acc;
    logic                  rend_acc;
    logic [RD_LATENCY-1:0] rend_pipe;
    logic [RD_LATENCY-1:0] host_pipe;

    // Grants are masked by rst_n so nothing reaches the RAM while in reset.
    always_comb begin
        force_host = host_valid && (starve_cnt == STARVE_MAX);
        host_acc   = rst_n && host_valid && (force_host || !rend_req);
        rend_acc   = rst_n && rend_req && !host_acc;
    end

    assign host_ready = host_acc;
    assign rend_gnt   = rend_acc;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        if (host_acc) begin
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            ram_wren  = host_we;
        end else if (rend_acc) begin
            ram_addr = rend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rend_pipe  <= '0;
            host_pipe  <= '0;
        end else begin
            if (!host_valid || host_acc) begin
                starve_cnt <= '0;
            end else if (rend_acc && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            rend_pipe[0] <= rend_acc;
            host_pipe[0] <= host_acc && !host_we;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rend_pipe[i] <= rend_pipe[i-1];
                host_pipe[i] <= host_pipe[i-1];
            end
        end
    end

    // Data is a shared passthrough; each side trusts only its own valid.
    assign rend_rvalid = rst_n && rend_pipe[RD_LATENCY-1];
    assign host_rvalid = rst_n && host_pipe[RD_LATENCY-1];
    assign rend_rdata  = ram_q;
    assign host_rdata  = ram_q;

endmodule

// File: tb/tb_palette_port_arbiter.sv
// Directed bench: three arbiters (RD_LATENCY 1..3) share stimulus, each backed by its own RAM model.
module tb_palette_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rend_req;
    logic [9:0]  rend_addr;
    logic        host_valid;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;

    logic        rend_gnt_a    [3];
    logic        rend_rvalid_a [3];
    logic [31:0] rend_rdata_a  [3];
    logic        host_ready_a  [3];
    logic        host_rvalid_a [3];
    logic [31:0] host_rdata_a  [3];
    logic [9:0]  ram_addr_a    [3];
    logic [31:0] ram_wdata_a   [3];
    logic        ram_wren_a    [3];
    logic [31:0] ram_q_a       [3];

    logic [31:0] mem [3][1024];
    logic [31:0] qp  [3][3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (ram_wren_a[m]) mem[m][ram_addr_a[m]] <= ram_wdata_a[m];
            qp[m][0] <= mem[m][ram_addr_a[m]];
            qp[m][1] <= qp[m][0];
            qp[m][2] <= qp[m][1];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        palette_port_arbiter #(.RD_LATENCY(g + 1), .MAX_STARVE(4)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .rend_req    (rend_req),
            .rend_addr   (rend_addr),
            .rend_gnt    (rend_gnt_a[g]),
            .rend_rvalid (rend_rvalid_a[g]),
            .rend_rdata  (rend_rdata_a[g]),
            .host_valid  (host_valid),
            .host_we     (host_we),
            .host_addr   (host_addr),
            .host_wdata  (host_wdata),
            .host_ready  (host_ready_a[g]),
            .host_rvalid (host_rvalid_a[g]),
            .host_rdata  (host_rdata_a[g]),
            .ram_addr    (ram_addr_a[g]),
            .ram_wdata   (ram_wdata_a[g]),
            .ram_wren    (ram_wren_a[g]),
            .ram_q       (ram_q_a[g])
        );
        assign ram_q_a[g] = qp[g][g];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        rend_req   = 1'b0;
        rend_addr  = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic drain;
        drive_idle();
        repeat (6) tick();
    endtask

    task automatic test_reset;
        logic eh;
        rst_n      = 1'b0;
        rend_req   = 1'b1;
        rend_addr  = 10'h155;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 10'h200;
        host_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if ({rend_gnt_a[g], host_ready_a[g], ram_wren_a[g], rend_rvalid_a[g], host_rvalid_a[g]} !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_ctrl inst%0d cyc%0d: gnt/rdy/wren/rv/hv got %b required 00000", g, k,
                             {rend_gnt_a[g], host_ready_a[g], ram_wren_a[g], rend_rvalid_a[g], host_rvalid_a[g]});
                end
                checks++;
                if (ram_addr_a[g] !== 10'h0 || ram_wdata_a[g] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_ram inst%0d cyc%0d: addr %h wdata %h required 0", g, k, ram_addr_a[g], ram_wdata_a[g]);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) host_valid = 1'b0;
            @(negedge clk);
            eh = (k == 4);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (host_ready_a[g] !== eh || rend_gnt_a[g] !== !eh || ram_wren_a[g] !== eh) begin
                    errors++;
                    $display("FAIL post_reset_grant inst%0d cyc%0d: rdy %b gnt %b wren %b required %b %b %b",
                             g, k, host_ready_a[g], rend_gnt_a[g], ram_wren_a[g], eh, !eh, eh);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_host_write_read;
        logic ev;
        for (int k = 0; k < 7; k++) begin
            drive_idle();
            if (k < 2) begin
                host_valid = 1'b1;
                host_we    = (k == 0);
                host_addr  = 10'h3FF;
                host_wdata = 32'h00FF_00AA;
            end
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (k < 2) begin
                    checks++;
                    if (host_ready_a[g] !== 1'b1 || ram_addr_a[g] !== 10'h3FF) begin
                        errors++;
                        $display("FAIL host_wr_rd_grant inst%0d cyc%0d: rdy %b addr %h required 1 3ff", g, k, host_ready_a[g], ram_addr_a[g]);
                    end
                end
                checks++;
                if (ram_wren_a[g] !== (k == 0) || (k == 0 && ram_wdata_a[g] !== 32'h00FF_00AA)) begin
                    errors++;
                    $display("FAIL host_wr_wren inst%0d cyc%0d: wren %b wdata %h required %b 00ff00aa", g, k, ram_wren_a[g], ram_wdata_a[g], (k == 0));
                end
                ev = (k == 1 + g + 1);
                checks++;
                if (host_rvalid_a[g] !== ev || rend_rvalid_a[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL host_rd_valid inst%0d cyc%0d: hrv %b rrv %b required %b 0", g, k, host_rvalid_a[g], rend_rvalid_a[g], ev);
                end
                if (ev) begin
                    checks++;
                    if (host_rdata_a[g] !== 32'h00FF_00AA) begin
                        errors++;
                        $display("FAIL host_rd_data inst%0d: got %h required 00ff00aa", g, host_rdata_a[g]);
                    end
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_preload;
        for (int k = 0; k < 36; k++) begin
            drive_idle();
            if (k < 32) begin
                host_valid = 1'b1;
                host_we    = 1'b1;
                host_addr  = 10'(k);
                host_wdata = 32'(k * 3);
            end
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (host_ready_a[g] !== (k < 32) || ram_wren_a[g] !== (k < 32) || host_rvalid_a[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL preload_write inst%0d cyc%0d: rdy %b wren %b hrv %b required %b %b 0",
                             g, k, host_ready_a[g], ram_wren_a[g], host_rvalid_a[g], (k < 32), (k < 32));
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_starvation;
        logic eh;
        logic ev;
        for (int k = 0; k < 22; k++) begin
            drive_idle();
            rend_req   = (k <= 16);
            rend_addr  = 10'(k);
            host_valid = (k >= 10 && k <= 14);
            host_addr  = 10'd5;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (k <= 16) begin
                    eh = (k == 14);
                    checks++;
                    if (host_ready_a[g] !== eh || rend_gnt_a[g] !== !eh) begin
                        errors++;
                        $display("FAIL starve_grant inst%0d cyc%0d: rdy %b gnt %b required %b %b", g, k, host_ready_a[g], rend_gnt_a[g], eh, !eh);
                    end
                end
                ev = (k == 14 + g + 1);
                checks++;
                if (host_rvalid_a[g] !== ev || (ev && host_rdata_a[g] !== 32'd15)) begin
                    errors++;
                    $display("FAIL starve_host_read inst%0d cyc%0d: hrv %b data %h required %b 0000000f", g, k, host_rvalid_a[g], host_rdata_a[g], ev);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_render_stream;
        int  j;
        logic ev;
        for (int k = 0; k < 36; k++) begin
            drive_idle();
            rend_req  = (k < 32);
            rend_addr = 10'(k);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (rend_gnt_a[g] !== (k < 32)) begin
                    errors++;
                    $display("FAIL stream_grant inst%0d cyc%0d: got %b required %b", g, k, rend_gnt_a[g], (k < 32));
                end
                j  = k - (g + 1);
                ev = (j >= 0 && j < 32);
                checks++;
                if (rend_rvalid_a[g] !== ev || host_rvalid_a[g] !== 1'b0 || (ev && rend_rdata_a[g] !== 32'(j * 3))) begin
                    errors++;
                    $display("FAIL stream_return inst%0d cyc%0d: rv %b data %h hrv %b required %b %h 0",
                             g, k, rend_rvalid_a[g], rend_rdata_a[g], host_rvalid_a[g], ev, 32'(j * 3));
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_latency_sweep;
        int   tbl [12] = '{1, 2, 1, 2, 2, 1, 0, 1, 2, 0, 2, 1};
        int   kind;
        int   j;
        logic er;
        logic eh;
        for (int k = 0; k < 16; k++) begin
            drive_idle();
            kind       = (k < 12) ? tbl[k] : 0;
            rend_req   = (kind == 1);
            host_valid = (kind == 2);
            rend_addr  = 10'(8 + k);
            host_addr  = 10'(8 + k);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (rend_gnt_a[g] !== (kind == 1) || host_ready_a[g] !== (kind == 2)) begin
                    errors++;
                    $display("FAIL sweep_grant inst%0d cyc%0d: gnt %b rdy %b required %b %b", g, k, rend_gnt_a[g], host_ready_a[g], (kind == 1), (kind == 2));
                end
                j  = k - (g + 1);
                er = (j >= 0 && j < 12) ? (tbl[j] == 1) : 1'b0;
                eh = (j >= 0 && j < 12) ? (tbl[j] == 2) : 1'b0;
                checks++;
                if (rend_rvalid_a[g] !== er || host_rvalid_a[g] !== eh) begin
                    errors++;
                    $display("FAIL sweep_valid inst%0d cyc%0d: rv %b hv %b required %b %b", g, k, rend_rvalid_a[g], host_rvalid_a[g], er, eh);
                end
                checks++;
                if (rend_rvalid_a[g] && host_rvalid_a[g]) begin
                    errors++;
                    $display("FAIL sweep_overlap inst%0d cyc%0d: both rvalids 1 required at most one", g, k);
                end
                if (er || eh) begin
                    checks++;
                    if ((er ? rend_rdata_a[g] : host_rdata_a[g]) !== 32'((8 + j) * 3)) begin
                        errors++;
                        $display("FAIL sweep_data inst%0d cyc%0d: got %h required %h", g, k,
                                 (er ? rend_rdata_a[g] : host_rdata_a[g]), 32'((8 + j) * 3));
                    end
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midflight;
        logic eh;
        logic er;
        for (int k = 0; k < 11; k++) begin
            drive_idle();
            rst_n      = (k != 2);
            rend_req   = 1'b1;
            rend_addr  = 10'(k);
            host_valid = (k <= 7);
            host_addr  = 10'd7;
            @(negedge clk);
            eh = (k == 7);
            er = (k != 2) && !eh;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (host_ready_a[g] !== eh || rend_gnt_a[g] !== er) begin
                    errors++;
                    $display("FAIL midflight_grant inst%0d cyc%0d: rdy %b gnt %b required %b %b", g, k, host_ready_a[g], rend_gnt_a[g], eh, er);
                end
                if (k >= 2 && k <= 3 + g + 1) begin
                    checks++;
                    if (rend_rvalid_a[g] !== (k == 3 + g + 1)) begin
                        errors++;
                        $display("FAIL midflight_rvalid inst%0d cyc%0d: got %b required %b", g, k, rend_rvalid_a[g], (k == 3 + g + 1));
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_drop_valid;
        logic eh;
        for (int k = 0; k < 10; k++) begin
            drive_idle();
            rend_req   = 1'b1;
            rend_addr  = 10'(k);
            host_valid = (k < 2) || (k >= 3 && k <= 7);
            host_we    = 1'b1;
            host_addr  = 10'h3FF;
            host_wdata = 32'h1234_5678;
            @(negedge clk);
            eh = (k == 7);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (host_ready_a[g] !== eh || ram_wren_a[g] !== eh || rend_gnt_a[g] !== !eh) begin
                    errors++;
                    $display("FAIL drop_valid inst%0d cyc%0d: rdy %b wren %b gnt %b required %b %b %b",
                             g, k, host_ready_a[g], ram_wren_a[g], rend_gnt_a[g], eh, eh, !eh);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        tick();
        test_reset();
        test_host_write_read();
        test_preload();
        test_starvation();
        test_render_stream();
        test_latency_sweep();
        test_reset_midflight();
        test_drop_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
